// File: rtl/peripheral_timer_multi_biu.sv
// AHB-Lite multi-channel down-counter timer: per-channel prescaler, reload value, one-shot or
// periodic mode and interrupt, plus a registered combined interrupt line.
module peripheral_timer_multi_biu #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned TIMERS     = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PRE_WIDTH  = 8
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP,
  output logic [TIMERS-1:0]     tint_ch,
  output logic                  tint
);

  // Word index HADDR[8:2]: [6:2] selects block (0 = global, n+1 = channel n), [1:0] the register.
  logic                  addr_ok;
  logic [3:0]            be_d, be_q;
  logic [6:0]            waddr_q;
  logic                  wr_q;
  logic [HDATA_SIZE-1:0] rdata_q;
  logic [HDATA_SIZE-1:0] wmask, wval;
  logic [TIMERS-1:0]     w1c;

  logic                  gen_q, gen_d;
  logic [TIMERS-1:0]     ipend_q, ipend_d, ien_q, ien_d;
  logic [TIMERS-1:0]     en_q, en_d, per_q, per_d;
  logic [TIMERS-1:0]     active, tick_s;
  logic [PRE_WIDTH-1:0]  pre_q [TIMERS];
  logic [PRE_WIDTH-1:0]  pre_d [TIMERS];
  logic [PRE_WIDTH-1:0]  pcnt_q [TIMERS];
  logic [PRE_WIDTH-1:0]  pcnt_d [TIMERS];
  logic [CNT_WIDTH-1:0]  load_q [TIMERS];
  logic [CNT_WIDTH-1:0]  load_d [TIMERS];
  logic [CNT_WIDTH-1:0]  cnt_q [TIMERS];
  logic [CNT_WIDTH-1:0]  cnt_d [TIMERS];
  logic [TIMERS-1:0]     tint_ch_q;
  logic                  tint_q;

  // Only the low address bits are decoded; the block aliases across its HSEL window.
  logic unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HTRANS[0], HADDR[HADDR_SIZE-1:9]};

  function automatic logic [HDATA_SIZE-1:0] reg_read(input logic [6:0] widx);
    logic [HDATA_SIZE-1:0] v;
    v = '0;
    if (widx[6:2] == 5'd0) begin
      case (widx[1:0])
        2'd0:    v[0] = gen_q;
        2'd1:    v[TIMERS-1:0] = ipend_q;
        2'd2:    v[TIMERS-1:0] = ien_q;
        default: ;
      endcase
    end
    for (int unsigned n = 0; n < TIMERS; n++) begin
      if (widx[6:2] == 5'(n + 1)) begin
        case (widx[1:0])
          2'd0: begin
            v[0]             = en_q[n];
            v[1]             = per_q[n];
            v[8 +: PRE_WIDTH] = pre_q[n];
          end
          2'd1:    v[CNT_WIDTH-1:0] = load_q[n];
          2'd2:    v[CNT_WIDTH-1:0] = cnt_q[n];
          default: ;
        endcase
      end
    end
    return v;
  endfunction

  assign addr_ok = HREADY & HSEL & HTRANS[1];

  always_comb begin
    case (HSIZE)
      3'd0:    be_d = 4'b0001 << HADDR[1:0];
      3'd1:    be_d = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // Disabled byte lanes keep the register's current value.
  always_comb begin
    wmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    wval  = (reg_read(waddr_q) & ~wmask) | (HWDATA & wmask);
    w1c   = HWDATA[TIMERS-1:0] & wmask[TIMERS-1:0];
  end

  always_comb begin
    for (int unsigned n = 0; n < TIMERS; n++) begin
      active[n] = gen_q & en_q[n];
      tick_s[n] = active[n] && (pcnt_q[n] == pre_q[n]);
    end
  end

  // Bus writes are applied after the hardware update so they win any same-cycle conflict,
  // except the W1C of IPENDING, which loses to a hardware set.
  always_comb begin
    gen_d   = gen_q;
    ien_d   = ien_q;
    ipend_d = ipend_q;
    en_d    = en_q;
    per_d   = per_q;
    pre_d   = pre_q;
    pcnt_d  = pcnt_q;
    load_d  = load_q;
    cnt_d   = cnt_q;

    if (wr_q && waddr_q[6:2] == 5'd0) begin
      case (waddr_q[1:0])
        2'd0:    gen_d = wval[0];
        2'd1:    ipend_d = ipend_q & ~w1c;
        2'd2:    ien_d = wval[TIMERS-1:0];
        default: ;
      endcase
    end

    for (int unsigned n = 0; n < TIMERS; n++) begin
      if (active[n]) pcnt_d[n] = tick_s[n] ? '0 : pcnt_q[n] + 1'b1;
      if (tick_s[n]) begin
        if (cnt_q[n] != '0) begin
          cnt_d[n] = cnt_q[n] - 1'b1;
        end else begin
          ipend_d[n] = 1'b1;
          if (per_q[n]) cnt_d[n] = load_q[n];
          else          en_d[n]  = 1'b0;
        end
      end
      if (wr_q && waddr_q[6:2] == 5'(n + 1)) begin
        case (waddr_q[1:0])
          2'd0: begin
            en_d[n]   = wval[0];
            per_d[n]  = wval[1];
            pre_d[n]  = wval[8 +: PRE_WIDTH];
            pcnt_d[n] = '0;
          end
          2'd1:    load_d[n] = wval[CNT_WIDTH-1:0];
          2'd2:    cnt_d[n]  = wval[CNT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      gen_q     <= 1'b0;
      ipend_q   <= '0;
      ien_q     <= '0;
      en_q      <= '0;
      per_q     <= '0;
      tint_ch_q <= '0;
      tint_q    <= 1'b0;
      for (int unsigned n = 0; n < TIMERS; n++) begin
        pre_q[n]  <= '0;
        pcnt_q[n] <= '0;
        load_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
    end else begin
      wr_q <= addr_ok & HWRITE;
      if (addr_ok) begin
        waddr_q <= HADDR[8:2];
        be_q    <= be_d;
      end
      if (addr_ok && !HWRITE) rdata_q <= reg_read(HADDR[8:2]);
      gen_q     <= gen_d;
      ipend_q   <= ipend_d;
      ien_q     <= ien_d;
      en_q      <= en_d;
      per_q     <= per_d;
      tint_ch_q <= ipend_q & ien_q;
      tint_q    <= |(ipend_q & ien_q);
      for (int unsigned n = 0; n < TIMERS; n++) begin
        pre_q[n]  <= pre_d[n];
        pcnt_q[n] <= pcnt_d[n];
        load_q[n] <= load_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign tint_ch   = tint_ch_q;
  assign tint      = tint_q;

endmodule

// File: tb/tb_peripheral_timer_multi_biu.sv
// Bench for peripheral_timer_multi_biu: directed scenarios plus randomized runs checked against
// an arithmetic model of tick counts and expiries.
module tb_peripheral_timer_multi_biu;

  localparam int unsigned TIMERS = 4;
  localparam logic [31:0] GCTRL  = 32'h00;
  localparam logic [31:0] IPEND  = 32'h04;
  localparam logic [31:0] IEN    = 32'h08;

  logic              HRESETn, HCLK, HSEL, HWRITE, HREADYOUT, HREADY, HRESP, tint;
  logic [31:0]       HADDR, HWDATA, HRDATA;
  logic [2:0]        HSIZE, HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic [TIMERS-1:0] tint_ch;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  peripheral_timer_multi_biu #(.TIMERS(TIMERS)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADYOUT(HREADYOUT), .HREADY(HREADY), .HRESP(HRESP),
    .tint_ch(tint_ch), .tint(tint)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ctrl_a(input int unsigned n);  return 32'h10 + n * 16; endfunction
  function automatic logic [31:0] load_a(input int unsigned n);  return 32'h14 + n * 16; endfunction
  function automatic logic [31:0] count_a(input int unsigned n); return 32'h18 + n * 16; endfunction

  // Expected state after a active (running) cycles from a fresh enable with COUNT=c.
  function automatic void model(input int unsigned a, input int unsigned pre,
      input int unsigned ld, input int unsigned c, input bit per,
      output int unsigned cnt, output bit pend, output bit en);
    int unsigned k;
    k = a / (pre + 1);
    if (k <= c) begin
      cnt = c - k; pend = 1'b0; en = 1'b1;
    end else if (!per) begin
      cnt = 0; pend = 1'b1; en = 1'b0;
    end else begin
      cnt = ld - ((k - c - 1) % (ld + 1)); pend = 1'b1; en = 1'b1;
    end
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_write(a, d, 3'd2);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'd2;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] a;
    n_cmp++;
    if (tint !== 1'b0 || tint_ch !== '0) begin
      n_bad++; $display("FAIL reset_irq: got tint=%b tint_ch=%b want 0/0", tint, tint_ch);
    end
    n_cmp++;
    if (HRDATA !== 32'h0) begin
      n_bad++; $display("FAIL reset_hrdata: got %h want 0", HRDATA);
    end
    for (int i = 0; i < 15; i++) begin
      a = (i < 3) ? 32'(i * 4) : 32'h10 + 32'((i - 3) / 3) * 16 + 32'(((i - 3) % 3) * 4);
      bus_read(a, rd);
      n_cmp++;
      if (rd !== 32'h0) begin
        n_bad++; $display("FAIL reset_reg[%h]: got %h want 0", a, rd);
      end
    end
  endtask

  task automatic test_periodic();
    int unsigned e0, w;
    logic [31:0] rd;
    bit exp_t;
    wr(GCTRL, 1); wr(IEN, 1); wr(load_a(0), 3); wr(count_a(0), 3);
    wr(ctrl_a(0), 32'h3);
    e0 = cyc;
    for (int g = 0; g < 20 && tint !== 1'b1; g++) tick(1);
    n_cmp++;
    if (cyc - e0 != 5) begin
      n_bad++; $display("FAIL periodic_first_irq: got %0d cycles want 5", cyc - e0);
    end
    n_cmp++;
    if (tint_ch !== 4'b0001) begin
      n_bad++; $display("FAIL periodic_tint_ch: got %b want 0001", tint_ch);
    end
    bus_read(IPEND, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_bad++; $display("FAIL periodic_ipend: got %h want 1", rd);
    end
    // Phase 0: W1C lands on an expiry edge; phase 2: between expiries.
    for (int ph = 0; ph < 4; ph += 2) begin
      for (int g = 0; g < 4 && ((cyc + 2 - e0) % 4) != ph; g++) tick(1);
      wr(IPEND, 1);
      w = cyc;
      for (int t = 1; t <= 8; t++) begin
        tick(1);
        exp_t = 1'b0;
        for (int unsigned e = w; e < cyc; e++) if (e > e0 && (e - e0) % 4 == 0) exp_t = 1'b1;
        n_cmp++;
        if (tint !== exp_t) begin
          n_bad++; $display("FAIL w1c_ph%0d_t%0d: got tint=%b want %b", ph, t, tint, exp_t);
        end
      end
    end
    wr(ctrl_a(0), 0); wr(IPEND, 32'hF);
  endtask

  task automatic test_oneshot();
    int unsigned e0;
    logic [31:0] rd;
    wr(IEN, 32'h2); wr(load_a(1), 2); wr(count_a(1), 2);
    wr(ctrl_a(1), 32'h401);
    e0 = cyc;
    for (int g = 0; g < 40 && tint_ch[1] !== 1'b1; g++) tick(1);
    n_cmp++;
    if (cyc - e0 != 16) begin
      n_bad++; $display("FAIL oneshot_irq_latency: got %0d cycles want 16", cyc - e0);
    end
    bus_read(ctrl_a(1), rd);
    n_cmp++;
    if (rd !== 32'h400) begin
      n_bad++; $display("FAIL oneshot_ctrl: got %h want 00000400", rd);
    end
    tick(20);
    bus_read(count_a(1), rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++; $display("FAIL oneshot_count: got %h want 0", rd);
    end
    bus_read(IPEND, rd);
    n_cmp++;
    if (rd !== 32'h2) begin
      n_bad++; $display("FAIL oneshot_ipend: got %h want 2", rd);
    end
    wr(IPEND, 32'h2);
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, base, data, expv;
    int unsigned ch, sz, off;
    wr(load_a(2), 32'h11223344);
    bus_write(load_a(2) + 1, 32'h0000AB00, 3'd0);
    bus_read(load_a(2), rd);
    n_cmp++;
    if (rd !== 32'h1122AB44) begin
      n_bad++; $display("FAIL byte_write_spec: got %h want 1122ab44", rd);
    end
    for (int it = 0; it < 8; it++) begin
      ch = $urandom_range(TIMERS - 1);
      sz = $urandom_range(2);
      off = (sz == 0) ? $urandom_range(3) : (sz == 1) ? 2 * $urandom_range(1) : 0;
      base = $urandom; data = $urandom;
      wr(load_a(ch), base);
      bus_write(load_a(ch) + off, data, 3'(sz));
      expv = base;
      for (int b = 0; b < 4; b++)
        if (b >= int'(off) && b < int'(off + (1 << sz))) expv[8*b +: 8] = data[8*b +: 8];
      bus_read(load_a(ch), rd);
      n_cmp++;
      if (rd !== expv) begin
        n_bad++; $display("FAIL byte_write_rand ch%0d sz%0d off%0d: got %h want %h",
                          ch, sz, off, rd, expv);
      end
    end
  endtask

  task automatic test_count_write_tick();
    logic [31:0] rd;
    wr(load_a(3), 32'h100); wr(count_a(3), 32'h100); wr(ctrl_a(3), 32'h3);
    tick(3);
    wr(count_a(3), 32'h55);
    bus_read(count_a(3), rd);
    n_cmp++;
    if (rd !== 32'h55) begin
      n_bad++; $display("FAIL count_write_wins: got %h want 55", rd);
    end
    bus_read(count_a(3), rd);
    n_cmp++;
    if (rd !== 32'h54) begin
      n_bad++; $display("FAIL count_after_write: got %h want 54", rd);
    end
    wr(ctrl_a(3), 0);
  endtask

  task automatic test_random_run();
    int unsigned ch, pre, ld, c, a_tot, e0, exp_cnt;
    bit per, exp_p, exp_en;
    logic [31:0] rd, ctrl_v;
    for (int it = 0; it < 10; it++) begin
      ch = $urandom_range(TIMERS - 1); pre = $urandom_range(3);
      ld = $urandom_range(6); c = $urandom_range(6); per = ($urandom_range(1) == 1);
      wr(GCTRL, 0);
      for (int n = 0; n < int'(TIMERS); n++) wr(ctrl_a(n), 0);
      wr(IPEND, 32'hF); wr(load_a(ch), ld); wr(count_a(ch), c);
      ctrl_v = (pre << 8) | (per ? 32'h2 : 32'h0) | 32'h1;
      wr(ctrl_a(ch), ctrl_v); wr(IEN, 32'h1 << ch);
      a_tot = 0;
      for (int seg = 0; seg < 2; seg++) begin
        wr(GCTRL, 1);
        e0 = cyc;
        tick($urandom_range(30));
        wr(GCTRL, 0);
        a_tot += cyc - e0;
        model(a_tot, pre, ld, c, per, exp_cnt, exp_p, exp_en);
        tick(3);
        bus_read(count_a(ch), rd);
        n_cmp++;
        if (rd !== 32'(exp_cnt)) begin
          n_bad++; $display("FAIL rand%0d_s%0d count ch%0d: got %h want %h", it, seg, ch, rd, exp_cnt);
        end
        bus_read(IPEND, rd);
        n_cmp++;
        if (rd !== (32'(exp_p) << ch)) begin
          n_bad++; $display("FAIL rand%0d_s%0d ipend: got %h want %h", it, seg, rd, 32'(exp_p) << ch);
        end
        n_cmp++;
        if (tint !== exp_p) begin
          n_bad++; $display("FAIL rand%0d_s%0d tint: got %b want %b", it, seg, tint, exp_p);
        end
        bus_read(ctrl_a(ch), rd);
        n_cmp++;
        if (rd !== ((ctrl_v & ~32'h1) | 32'(exp_en))) begin
          n_bad++; $display("FAIL rand%0d_s%0d ctrl: got %h want %h", it, seg, rd,
                            (ctrl_v & ~32'h1) | 32'(exp_en));
        end
      end
    end
    for (int n = 0; n < int'(TIMERS); n++) wr(ctrl_a(n), 0);
    wr(IPEND, 32'hF);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd;
    logic [31:0] regs [5];
    regs = '{GCTRL, IPEND, IEN, ctrl_a(0), count_a(0)};
    wr(GCTRL, 1); wr(IEN, 1); wr(load_a(0), 5); wr(count_a(0), 5); wr(ctrl_a(0), 32'h3);
    tick(20);
    n_cmp++;
    if (tint !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pre_tint: got %b want 1", tint);
    end
    bus_read(load_a(0), rd);
    #1 HRESETn = 1'b0;
    #1;
    n_cmp++;
    if (tint !== 1'b0 || tint_ch !== '0 || HRDATA !== 32'h0) begin
      n_bad++; $display("FAIL midreset_async: got tint=%b tint_ch=%b hrdata=%h want 0/0/0",
                        tint, tint_ch, HRDATA);
    end
    tick(2);
    HRESETn = 1'b1;
    tick(1);
    foreach (regs[i]) begin
      bus_read(regs[i], rd);
      n_cmp++;
      if (rd !== 32'h0) begin
        n_bad++; $display("FAIL midreset_reg[%h]: got %h want 0", regs[i], rd);
      end
    end
    tick(5);
    n_cmp++;
    if (tint !== 1'b0) begin
      n_bad++; $display("FAIL midreset_residual_tint: got %b want 0", tint);
    end
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = '0; HPROT = '0; HTRANS = 2'b00; HREADY = 1'b1;
    tick(3);
    HRESETn = 1'b1;
    tick(1);
    test_reset();
    test_periodic();
    test_oneshot();
    test_byte_write();
    test_count_write_tick();
    test_random_run();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
